// File: rtl/input_conditioner_pkg.sv
// Shared types and default sizing for the input conditioner.
// Four-state debounce FSM encoding plus synchroniser/debounce defaults.
package input_conditioner_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        CHK_HI    = 2'b01,
        STABLE_HI = 2'b11,
        CHK_LO    = 2'b10
    } cond_state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DEB_COUNT   = 4;

endpackage

// File: rtl/input_conditioner_sync_chain.sv
// Metastability synchroniser: STAGES flops clocked on the falling edge of clk_n.
// Latency STAGES edges; no backpressure.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk_n,
    input  logic clr_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(negedge clk_n or negedge clr_n) begin
        if (!clr_n) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// Debounced level conditioner with change/rise/fall pulses for a clock-enabled flop.
// Latency SYNC_STAGES+DEB_COUNT falling edges with sample_en high; sample_en=0 stalls the FSM.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEB_COUNT   = DEF_DEB_COUNT
) (
    input  logic clk_n,
    input  logic clr_n,
    input  logic raw_in,
    input  logic sample_en,
    output logic d_out,
    output logic ce_out,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int CW = $clog2(DEB_COUNT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_COUNT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic            sync;
    cond_state_t     state;
    logic [CW-1:0]   cnt;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_n (clk_n),
        .clr_n (clr_n),
        .d     (raw_in),
        .q     (sync)
    );

    // Pulses default low each edge so they can never stretch past one cycle.
    always_ff @(negedge clk_n or negedge clr_n) begin
        if (!clr_n) begin
            state  <= STABLE_LO;
            cnt    <= '0;
            ce_out <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            ce_out <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
            case (state)
                STABLE_LO: begin
                    if (sample_en && sync) begin
                        state <= CHK_HI;
                        cnt   <= CNT_ONE;
                    end
                end
                CHK_HI: begin
                    if (sample_en) begin
                        if (!sync) begin
                            state <= STABLE_LO;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state  <= STABLE_HI;
                            cnt    <= '0;
                            ce_out <= 1'b1;
                            rise   <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                STABLE_HI: begin
                    if (sample_en && !sync) begin
                        state <= CHK_LO;
                        cnt   <= CNT_ONE;
                    end
                end
                CHK_LO: begin
                    if (sample_en) begin
                        if (sync) begin
                            state <= STABLE_HI;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state  <= STABLE_LO;
                            cnt    <= '0;
                            ce_out <= 1'b1;
                            fall   <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state <= STABLE_LO;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Level and busy decode straight from the state flops.
    assign d_out = (state == STABLE_HI) || (state == CHK_LO);
    assign busy  = (state == CHK_HI) || (state == CHK_LO);

endmodule

// File: tb/tb_input_conditioner.sv
// Directed plus randomised bench for input_conditioner against a run-length debounce model.
module tb_input_conditioner;

    localparam int SS  = 2;
    localparam int DEB = 4;

    logic clk_n;
    logic clr_n;
    logic raw_in;
    logic sample_en;
    logic d_out, ce_out, rise, fall, busy;
    logic ff_q;

    int total;
    int bad;

    // Behavioural reference state
    logic [SS-1:0] m_sr;
    logic          m_level;
    int            m_run;
    logic          m_pulse, m_rise, m_fall;
    logic          m_q;

    input_conditioner #(
        .SYNC_STAGES (SS),
        .DEB_COUNT   (DEB)
    ) dut (
        .clk_n     (clk_n),
        .clr_n     (clr_n),
        .raw_in    (raw_in),
        .sample_en (sample_en),
        .d_out     (d_out),
        .ce_out    (ce_out),
        .rise      (rise),
        .fall      (fall),
        .busy      (busy)
    );

    // Downstream clock-enabled flop
    always @(negedge clk_n or negedge clr_n) begin
        if (!clr_n) ff_q <= 1'b0;
        else if (ce_out) ff_q <= d_out;
    end

    initial begin
        clk_n = 1'b1;
        forever #5 clk_n = ~clk_n;
    end

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sr    = '0;
        m_level = 1'b0;
        m_run   = 0;
        m_pulse = 1'b0;
        m_rise  = 1'b0;
        m_fall  = 1'b0;
        m_q     = 1'b0;
    endtask

    // A change is accepted on the DEB-th consecutive strobed sample that disagrees with the level.
    task automatic model_edge();
        logic s;
        if (clr_n) begin
            s = m_sr[SS-1];
            if (m_pulse) m_q = m_level;
            m_pulse = 1'b0;
            m_rise  = 1'b0;
            m_fall  = 1'b0;
            if (sample_en) begin
                if (s != m_level) begin
                    m_run++;
                    if (m_run == DEB) begin
                        m_level = s;
                        m_run   = 0;
                        m_pulse = 1'b1;
                        m_rise  = s;
                        m_fall  = !s;
                    end
                end else begin
                    m_run = 0;
                end
            end
            m_sr = {m_sr[SS-2:0], raw_in};
        end
    endtask

    function automatic logic [5:0] obs_vec();
        return {ff_q, busy, fall, rise, ce_out, d_out};
    endfunction

    function automatic logic [5:0] exp_vec();
        return {m_q, (m_run != 0), m_fall, m_rise, m_pulse, m_level};
    endfunction

    task automatic tick(input string tag);
        @(negedge clk_n);
        model_edge();
        @(posedge clk_n);
        check(tag, obs_vec(), exp_vec());
    endtask

    // Called at a rising edge; asserts reset mid-cycle and releases on the next rising edge.
    task automatic pulse_reset(input string tag);
        #2 clr_n = 1'b0;
        #1;
        model_reset();
        check(tag, obs_vec(), 6'b000000);
        @(negedge clk_n);
        model_edge();
        @(posedge clk_n);
        check(tag, obs_vec(), exp_vec());
        clr_n = 1'b1;
    endtask

    initial begin
        logic seen_pulse;
        int   hold;
        total     = 0;
        bad       = 0;
        clr_n     = 1'b0;
        raw_in    = 1'b0;
        sample_en = 1'b1;
        model_reset();
        #3;
        check("reset_state", obs_vec(), 6'b000000);
        @(posedge clk_n);
        @(posedge clk_n);
        clr_n = 1'b1;
        tick("idle");

        // Clean rise: pulse on edge 6, busy on edges 3..5
        raw_in = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick("rise_seq");
            if (i >= 3 && i <= 5) check("rise_busy", {5'b0, busy}, 6'b000001);
            if (i == 5) check("rise_edge5", {3'b0, rise, ce_out, d_out}, 6'b000000);
            if (i == 6) check("rise_edge6", {3'b0, rise, ce_out, d_out}, 6'b000111);
            if (i == 7) check("rise_edge7", {ff_q, busy, fall, rise, ce_out, d_out}, 6'b100001);
        end

        // Clean fall: pulse on edge 6
        raw_in = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick("fall_seq");
            if (i == 6) check("fall_edge6", {3'b0, fall, ce_out, d_out}, 6'b000110);
            if (i == 7) check("fall_edge7", {ff_q, 4'b0, d_out}, 6'b000000);
        end

        // Glitch of two cycles is rejected
        seen_pulse = 1'b0;
        raw_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick("glitch_hi");
            seen_pulse |= ce_out | rise;
        end
        raw_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick("glitch_lo");
            seen_pulse |= ce_out | rise;
        end
        check("glitch_result", {seen_pulse, busy, 3'b0, d_out}, 6'b000000);

        // Strobe 1-in-3 with raw held high
        raw_in = 1'b1;
        for (int i = 0; i < 24; i++) begin
            sample_en = (i % 3 == 0);
            tick("strobe_seq");
        end
        check("strobe_level", {5'b0, d_out}, 6'b000001);
        sample_en = 1'b1;
        raw_in = 1'b0;
        for (int i = 0; i < 8; i++) tick("strobe_back");

        // Reset while qualifying with cnt=3
        raw_in = 1'b1;
        for (int i = 0; i < 5; i++) tick("preclr");
        check("preclr_busy", {5'b0, busy}, 6'b000001);
        pulse_reset("clr_midqual");
        for (int i = 1; i <= 6; i++) begin
            tick("postclr");
            if (i == 1) check("postclr_nopulse", {3'b0, ce_out, rise, d_out}, 6'b000000);
            if (i == 5) check("postclr_edge5", {5'b0, d_out}, 6'b000000);
            if (i == 6) check("postclr_edge6", {4'b0, ce_out, d_out}, 6'b000011);
        end

        // Downstream flop tracks 0->1->0
        raw_in = 1'b0;
        for (int i = 0; i < 8; i++) tick("hook_lo");
        check("hook_q_lo", {ff_q, 4'b0, d_out}, 6'b000000);
        raw_in = 1'b1;
        for (int i = 0; i < 8; i++) tick("hook_hi");
        check("hook_q_hi", {ff_q, 4'b0, d_out}, 6'b100001);
        raw_in = 1'b0;
        for (int i = 0; i < 8; i++) tick("hook_lo2");
        check("hook_q_lo2", {ff_q, 4'b0, d_out}, 6'b000000);

        // Random holds, strobes and occasional reset
        for (int n = 0; n < 150; n++) begin
            raw_in = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 8);
            for (int k = 0; k < hold; k++) begin
                sample_en = ($urandom_range(0, 9) < 7);
                tick("random");
            end
            if ($urandom_range(0, 39) == 0) pulse_reset("random_clr");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
